// File: rtl/enemy_bullet_arbiter.sv
// Purpose : binds requesting enemy tanks (round-robin) to free bullet engines and tracks slot ownership.
// Latency : 1 cycle from a sampled eligible request to the registered grant/launch pulse.
// Backpr. : requests wait while every slot is busy; a request dropped before its grant is lost.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   enable      - game running; low clears all state synchronously and blocks grants/releases
//   fire_req    - per-tank level request
//   slot_done   - per-slot 1-cycle "bullet finished" pulse
//   grant       - one-hot pulse, tank granted
//   launch      - one-hot pulse, bullet engine to start (same cycle as grant)
//   launch_tid  - index of the last granted tank
//   slot_busy   - slot holds a live bullet
//   tank_live   - tank has a live bullet
module enemy_bullet_arbiter #(
    parameter int N_TANK   = 4,
    parameter int N_SLOT   = 4,
    parameter int COOLDOWN = 25000000,
    parameter int CD_W     = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_TANK-1:0] fire_req,
    input  logic [N_SLOT-1:0] slot_done,
    output logic [N_TANK-1:0] grant,
    output logic [N_SLOT-1:0] launch,
    output logic [2:0]        launch_tid,
    output logic [N_SLOT-1:0] slot_busy,
    output logic [N_TANK-1:0] tank_live
);

    localparam int PTR_W = (N_TANK > 1) ? $clog2(N_TANK) : 1;
    // The grant edge itself counts as the first cooldown cycle, so the next grant
    // to the same tank can land exactly COOLDOWN edges after the previous one.
    localparam logic [CD_W-1:0] CD_LOAD = (COOLDOWN > 0) ? CD_W'(COOLDOWN - 1) : '0;

    logic [N_TANK-1:0] grant_q,     grant_d;
    logic [N_SLOT-1:0] launch_q,    launch_d;
    logic [2:0]        tid_q,       tid_d;
    logic [N_SLOT-1:0] busy_q,      busy_d;
    logic [N_TANK-1:0] live_q,      live_d;
    logic [PTR_W-1:0]  rr_q,        rr_d;
    logic [CD_W-1:0]   cd_q    [N_TANK];
    logic [CD_W-1:0]   cd_d    [N_TANK];
    logic [2:0]        owner_q [N_SLOT];
    logic [2:0]        owner_d [N_SLOT];

    logic [N_TANK-1:0] elig;
    logic              win_vld;
    logic [2:0]        win_tid;
    logic [N_TANK-1:0] win_oh;
    logic [PTR_W-1:0]  win_next;
    logic              slot_vld;
    int                slot_sel;
    logic [N_SLOT-1:0] slot_oh;
    logic              do_grant;
    logic [N_SLOT-1:0] rel;
    logic [N_TANK-1:0] tank_clr;

    // Eligibility is judged on pre-edge state only.
    always_comb begin
        elig = '0;
        for (int t = 0; t < N_TANK; t++) begin
            elig[t] = enable && fire_req[t] && !live_q[t] && (cd_q[t] == '0);
        end
    end

    // Round-robin search starting at rr_q, wrapping modulo N_TANK.
    always_comb begin
        int idx;
        int nxt;
        idx      = 0;
        nxt      = 0;
        win_vld  = 1'b0;
        win_tid  = '0;
        win_oh   = '0;
        win_next = '0;
        for (int k = 0; k < N_TANK; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_TANK) idx = idx - N_TANK;
            if (!win_vld && elig[idx]) begin
                win_vld     = 1'b1;
                win_tid     = 3'(idx);
                win_oh[idx] = 1'b1;
                nxt         = idx + 1;
                if (nxt >= N_TANK) nxt = 0;
                win_next    = PTR_W'(nxt);
            end
        end
    end

    // Lowest-index free slot.
    always_comb begin
        slot_vld = 1'b0;
        slot_sel = 0;
        slot_oh  = '0;
        for (int s = 0; s < N_SLOT; s++) begin
            if (!slot_vld && !busy_q[s]) begin
                slot_vld    = 1'b1;
                slot_sel    = s;
                slot_oh[s]  = 1'b1;
            end
        end
    end

    assign do_grant = win_vld && slot_vld;

    // Releases only act on slots that are actually busy; several may retire at once.
    always_comb begin
        rel      = enable ? (slot_done & busy_q) : '0;
        tank_clr = '0;
        for (int t = 0; t < N_TANK; t++) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (rel[s] && (owner_q[s] == 3'(t))) tank_clr[t] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_d  = do_grant ? win_oh  : '0;
        launch_d = do_grant ? slot_oh : '0;
        tid_d    = do_grant ? win_tid : tid_q;
        rr_d     = do_grant ? win_next : rr_q;
        // A freshly granted slot/tank was free pre-edge, so set and clear never overlap.
        busy_d   = (busy_q & ~rel) | launch_d;
        live_d   = (live_q & ~tank_clr) | grant_d;
        for (int t = 0; t < N_TANK; t++) begin
            if (grant_d[t])           cd_d[t] = CD_LOAD;
            else if (cd_q[t] != '0)   cd_d[t] = cd_q[t] - CD_W'(1);
            else                      cd_d[t] = cd_q[t];
        end
        for (int s = 0; s < N_SLOT; s++) begin
            owner_d[s] = owner_q[s];
        end
        if (do_grant) owner_d[slot_sel] = win_tid;

        // Game not running: everything returns to the post-reset state.
        if (!enable) begin
            grant_d  = '0;
            launch_d = '0;
            tid_d    = '0;
            rr_d     = '0;
            busy_d   = '0;
            live_d   = '0;
            for (int t = 0; t < N_TANK; t++) cd_d[t]    = '0;
            for (int s = 0; s < N_SLOT; s++) owner_d[s] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            launch_q <= '0;
            tid_q    <= '0;
            rr_q     <= '0;
            busy_q   <= '0;
            live_q   <= '0;
            for (int t = 0; t < N_TANK; t++) cd_q[t]    <= '0;
            for (int s = 0; s < N_SLOT; s++) owner_q[s] <= '0;
        end else begin
            grant_q  <= grant_d;
            launch_q <= launch_d;
            tid_q    <= tid_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            live_q   <= live_d;
            for (int t = 0; t < N_TANK; t++) cd_q[t]    <= cd_d[t];
            for (int s = 0; s < N_SLOT; s++) owner_q[s] <= owner_d[s];
        end
    end

    assign grant      = grant_q;
    assign launch     = launch_q;
    assign launch_tid = tid_q;
    assign slot_busy  = busy_q;
    assign tank_live  = live_q;

endmodule

// File: tb/tb_enemy_bullet_arbiter.sv
module tb_enemy_bullet_arbiter;

    localparam int NT  = 4;
    localparam int NS  = 2;
    localparam int CD  = 4;
    localparam int CDW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NT-1:0] fire_req;
    logic [NS-1:0] slot_done;
    logic [NT-1:0] grant;
    logic [NS-1:0] launch;
    logic [2:0]    launch_tid;
    logic [NS-1:0] slot_busy;
    logic [NT-1:0] tank_live;

    enemy_bullet_arbiter #(
        .N_TANK(NT), .N_SLOT(NS), .COOLDOWN(CD), .CD_W(CDW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fire_req(fire_req), .slot_done(slot_done),
        .grant(grant), .launch(launch), .launch_tid(launch_tid),
        .slot_busy(slot_busy), .tank_live(tank_live)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT-1:0] g;
        logic [NS-1:0] l;
        logic [2:0]    tid;
        logic [NS-1:0] b;
        logic [NT-1:0] t;
    } obs_t;

    typedef struct {
        logic          en;
        logic [NT-1:0] req;
        logic [NS-1:0] done;
        obs_t          exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t sb[$];
    vec_t vt[14];

    function automatic vec_t mk(logic en, logic [NT-1:0] req, logic [NS-1:0] done,
                                logic [NT-1:0] g, logic [NS-1:0] l, logic [2:0] tid,
                                logic [NS-1:0] b, logic [NT-1:0] t);
        vec_t v;
        v.en = en; v.req = req; v.done = done;
        v.exp.g = g; v.exp.l = l; v.exp.tid = tid; v.exp.b = b; v.exp.t = t;
        return v;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.g = grant; o.l = launch; o.tid = launch_tid; o.b = slot_busy; o.t = tank_live;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got grant=%b launch=%b tid=%0d busy=%b live=%b, want grant=%b launch=%b tid=%0d busy=%b live=%b",
                     name, act.g, act.l, act.tid, act.b, act.t, exp.g, exp.l, exp.tid, exp.b, exp.t);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop enable for one edge: leaves rr pointer, cooldowns and slots cleared.
    task automatic clean();
        enable    = 1'b0;
        fire_req  = '0;
        slot_done = '0;
        tick();
        enable    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t zero;
        zero = '0;

        // Hand-derived vectors: N_SLOT=2, 3 cooldown decrements after the grant edge.
        vt[0]  = mk(1, 4'b0001, 2'b00, 4'b0001, 2'b01, 3'd0, 2'b01, 4'b0001);
        vt[1]  = mk(1, 4'b0000, 2'b00, 4'b0000, 2'b00, 3'd0, 2'b01, 4'b0001);
        vt[2]  = mk(1, 4'b1111, 2'b00, 4'b0010, 2'b10, 3'd1, 2'b11, 4'b0011);
        vt[3]  = mk(1, 4'b1111, 2'b00, 4'b0000, 2'b00, 3'd1, 2'b11, 4'b0011); // pool full
        vt[4]  = mk(1, 4'b1111, 2'b01, 4'b0000, 2'b00, 3'd1, 2'b10, 4'b0010); // release, not reused yet
        vt[5]  = mk(1, 4'b1111, 2'b00, 4'b0100, 2'b01, 3'd2, 2'b11, 4'b0110); // slot 0 to next RR tank
        vt[6]  = mk(1, 4'b1111, 2'b11, 4'b0000, 2'b00, 3'd2, 2'b00, 4'b0000); // double release
        vt[7]  = mk(1, 4'b1111, 2'b00, 4'b1000, 2'b01, 3'd3, 2'b01, 4'b1000);
        vt[8]  = mk(1, 4'b1111, 2'b00, 4'b0001, 2'b10, 3'd0, 2'b11, 4'b1001); // RR wraps to tank 0
        vt[9]  = mk(0, 4'b1111, 2'b11, 4'b0000, 2'b00, 3'd0, 2'b00, 4'b0000); // enable low clears
        vt[10] = mk(0, 4'b0000, 2'b01, 4'b0000, 2'b00, 3'd0, 2'b00, 4'b0000);
        vt[11] = mk(1, 4'b0001, 2'b00, 4'b0001, 2'b01, 3'd0, 2'b01, 4'b0001); // cd of tank 0 was cleared
        vt[12] = mk(1, 4'b0011, 2'b10, 4'b0010, 2'b10, 3'd1, 2'b11, 4'b0011); // done on free slot ignored
        vt[13] = mk(1, 4'b0011, 2'b01, 4'b0000, 2'b00, 3'd1, 2'b10, 4'b0010);

        rst_n = 1'b0; enable = 1'b0; fire_req = '0; slot_done = '0;
        #12;
        check_obs("reset_state", observe(), zero);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            enable    = vt[i].en;
            fire_req  = vt[i].req;
            slot_done = vt[i].done;
            sb.push_back(vt[i].exp);
            tick();
            check_obs($sformatf("vec%0d", i), observe(), sb.pop_front());
        end

        // Grant order with everyone requesting, each bullet done 2 cycles after launch.
        begin
            int exp_order[$];
            int dly[NS];
            int got;
            exp_order = '{0, 1, 2, 3, 0};
            for (int s = 0; s < NS; s++) dly[s] = 0;
            got = 0;
            clean();
            fire_req = 4'b1111;
            for (int c = 0; c < 60 && got < 5; c++) begin
                tick();
                if (grant != '0) begin
                    int idx;
                    idx = -1;
                    check_val("order_onehot", $countones(grant), 1);
                    for (int t = 0; t < NT; t++) if (grant[t]) idx = t;
                    check_val($sformatf("order_grant%0d", got), idx, exp_order.pop_front());
                    got++;
                end
                slot_done = '0;
                for (int s = 0; s < NS; s++) begin
                    if (dly[s] > 0) begin
                        dly[s]--;
                        if (dly[s] == 0) slot_done[s] = 1'b1;
                    end
                end
                for (int s = 0; s < NS; s++) if (launch[s]) dly[s] = 1;
            end
            check_val("order_count", got, 5);
            fire_req  = '0;
            slot_done = '0;
        end

        // Release and request in the same cycle: grant only on the following edge.
        clean();
        fire_req = 4'b0010;
        tick();
        check_val("same_first_grant", int'(grant), 2);
        fire_req = '0;
        repeat (6) tick();
        fire_req  = 4'b0010;
        slot_done = 2'b01;
        tick();
        check_val("same_cycle_no_grant", int'(grant), 0);
        check_val("same_cycle_freed", int'(slot_busy), 0);
        slot_done = '0;
        tick();
        check_val("same_next_grant", int'(grant), 2);
        check_val("same_next_launch", int'(launch), 1);
        fire_req = '0;

        // Cooldown spacing: lone tank 2, bullet done one cycle after launch.
        begin
            int first;
            int second;
            first  = -1;
            second = -1;
            clean();
            fire_req = 4'b0100;
            for (int c = 0; c < 40 && second < 0; c++) begin
                tick();
                if (grant[2]) begin
                    if (first < 0) first = c;
                    else           second = c;
                end
                slot_done = launch;
            end
            check_val("cooldown_first_at", first, 0);
            check_val("cooldown_gap", second - first, CD);
            fire_req  = '0;
            slot_done = '0;
        end

        // Asynchronous reset with two live bullets.
        clean();
        fire_req = 4'b0011;
        tick();
        tick();
        check_val("rst_pre_busy", int'(slot_busy), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("rst_async", observe(), zero);
        tick();
        check_obs("rst_held", observe(), zero);
        rst_n    = 1'b1;
        fire_req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
